score_popup_sched: RTL and testbench



---
 rtl/popup_pkg.sv | 60 ++++++
 rtl/popup_fifo.sv | 73 +++++++
 rtl/score_popup_sched.sv | 203 ++++++++++++++++++++
 tb/tb_score_popup_sched.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/popup_pkg.sv
// Shared definitions for the score/level popup scheduler.
// Contents:
//   popup_state_e  - popup phase encoding (IDLE, RISE, HOLD, FADE)
//   ASCII_*        - character codes used to build popup text
//   TEXT_BLANK     - three spaces, the text shown while no popup is up
//   to_two_digits  - saturating binary-to-BCD conversion (0..99)
//   sat_fade       - fade amount for a given fade frame, clamped to 8'hFF
//   award_text     - "+NN" text for a points value
//   level_text     - "LVn" text for a level number
package popup_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RISE = 2'd1,
        ST_HOLD = 2'd2,
        ST_FADE = 2'd3
    } popup_state_e;

    localparam logic [7:0]  ASCII_SPACE = 8'h20;
    localparam logic [7:0]  ASCII_PLUS  = 8'h2B;
    localparam logic [7:0]  ASCII_L     = 8'h4C;
    localparam logic [7:0]  ASCII_V     = 8'h56;
    localparam logic [7:0]  ASCII_ZERO  = 8'h30;
    localparam logic [23:0] TEXT_BLANK  = {ASCII_SPACE, ASCII_SPACE, ASCII_SPACE};

    // Returns {tens, ones} in BCD; values above 99 are shown as 99.
    function automatic logic [7:0] to_two_digits(input logic [7:0] points);
        logic [7:0] sat;
        logic [3:0] tens;
        logic [3:0] ones;
        sat  = (points > 8'd99) ? 8'd99 : points;
        tens = 4'(sat / 8'd10);
        ones = 4'(sat % 8'd10);
        return {tens, ones};
    endfunction

    // k-th fade frame amount, k*step clamped at full fade.
    function automatic logic [7:0] sat_fade(input logic [31:0] k, input logic [31:0] step);
        logic [31:0] prod;
        prod = k * step;
        return (prod > 32'd255) ? 8'hFF : prod[7:0];
    endfunction

    // "+NN": a zero tens digit is blanked so small awards read "+ 5".
    function automatic logic [23:0] award_text(input logic [7:0] points);
        logic [7:0] bcd;
        logic [7:0] char1;
        bcd   = to_two_digits(points);
        char1 = (bcd[7:4] == 4'd0) ? ASCII_SPACE : (ASCII_ZERO + {4'd0, bcd[7:4]});
        return {ASCII_PLUS, char1, ASCII_ZERO + {4'd0, bcd[3:0]}};
    endfunction

    // "LVn": only one digit of room, so levels above 9 show as 9.
    function automatic logic [23:0] level_text(input logic [3:0] lvl);
        logic [3:0] digit;
        digit = (lvl > 4'd9) ? 4'd9 : lvl;
        return {ASCII_L, ASCII_V, ASCII_ZERO + {4'd0, digit}};
    endfunction

endpackage

// File: rtl/popup_fifo.sv
// Small synchronous FIFO holding pending award values.
// Ports:
//   frame_clk, reset - clock, asynchronous active-high reset
//   flush            - synchronous empty; stored data becomes don't-care
//   push, din        - write when not full
//   pop              - read-advance when not empty
//   full, empty      - occupancy flags decoded from the count register
//   dout             - current head entry (valid when !empty)
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module popup_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             frame_clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign dout      = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping; a push and pop together keep the count.
    always_ff @(posedge frame_clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; data needs no reset because empty masks it.
    always_ff @(posedge frame_clk) begin
        if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/score_popup_sched.sv
// Frame-rate scheduler for the "+NN" / "LVn" popup beside the board.
// Ports:
//   frame_clk, reset         - one tick per VGA frame, async active-high reset
//   clear                    - synchronous flush on game over / restart
//   award_valid/points/ready - award request handshake (ready = queue not full)
//   lvl_valid, lvl_num       - level-up pulse and new level
//   popup_on, popup_text     - visibility and {char2,char1,char0} ASCII codes
//   pointer                  - Y offset below the popup base row
//   fade                     - amount subtracted from white
//   busy                     - popup active or any request pending
// A popup rises for RISE_FRAMES+1 frames, holds for HOLD_FRAMES and fades for
// FADE_FRAMES, then the scheduler idles at least one frame before the next.
module score_popup_sched
    import popup_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int RISE_FRAMES = 16,
    parameter int HOLD_FRAMES = 30,
    parameter int FADE_FRAMES = 32,
    parameter int FADE_STEP   = 8
) (
    input  logic        frame_clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        award_valid,
    input  logic [7:0]  award_points,
    output logic        award_ready,
    input  logic        lvl_valid,
    input  logic [3:0]  lvl_num,
    output logic        popup_on,
    output logic [23:0] popup_text,
    output logic [10:0] pointer,
    output logic [7:0]  fade,
    output logic        busy
);

    localparam int HOLD_W = $clog2(HOLD_FRAMES) + 1;
    localparam int FADE_W = $clog2(FADE_FRAMES) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_FRAMES - 1);
    localparam logic [FADE_W-1:0] FADE_LAST   = FADE_W'(FADE_FRAMES);
    localparam logic [10:0]       RISE_START  = 11'(RISE_FRAMES);
    localparam logic [31:0]       FADE_STEP_U = 32'(FADE_STEP);

    popup_state_e      state_r,     state_n;
    logic [10:0]       pointer_r,   pointer_n;
    logic [HOLD_W-1:0] hold_cnt_r,  hold_cnt_n;
    logic [FADE_W-1:0] fade_cnt_r,  fade_cnt_n;
    logic [7:0]        fade_r,      fade_n;
    logic [23:0]       text_r,      text_n;
    logic              popup_on_r,  popup_on_n;
    logic              lvl_pend_r,  lvl_pend_n;
    logic [3:0]        lvl_num_r,   lvl_num_n;

    logic              fifo_push_s;
    logic              fifo_pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [7:0]        fifo_dout_s;

    // Ready is taken from the pre-pop occupancy; clear drops a same-cycle push.
    assign award_ready = !fifo_full_s;
    assign fifo_push_s = award_valid && !fifo_full_s && !clear;
    assign busy        = (state_r != ST_IDLE) || !fifo_empty_s || lvl_pend_r;

    assign popup_on    = popup_on_r;
    assign popup_text  = text_r;
    assign pointer     = pointer_r;
    assign fade        = fade_r;

    popup_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .frame_clk (frame_clk),
        .reset     (reset),
        .flush     (clear),
        .push      (fifo_push_s),
        .din       (award_points),
        .pop       (fifo_pop_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .dout      (fifo_dout_s)
    );

    // Phase sequencing, load arbitration and next values of every output.
    always_comb begin
        state_n    = state_r;
        pointer_n  = pointer_r;
        hold_cnt_n = hold_cnt_r;
        fade_cnt_n = fade_cnt_r;
        fade_n     = fade_r;
        text_n     = text_r;
        popup_on_n = popup_on_r;
        fifo_pop_s = 1'b0;
        lvl_pend_n = lvl_pend_r;
        lvl_num_n  = lvl_num_r;

        if (clear) begin
            state_n    = ST_IDLE;
            pointer_n  = 11'd0;
            hold_cnt_n = {HOLD_W{1'b0}};
            fade_cnt_n = {FADE_W{1'b0}};
            fade_n     = 8'd0;
            text_n     = TEXT_BLANK;
            popup_on_n = 1'b0;
            lvl_pend_n = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Level-ups win over queued awards; one load per frame.
                    if (lvl_pend_r) begin
                        text_n     = level_text(lvl_num_r);
                        lvl_pend_n = 1'b0;
                        state_n    = ST_RISE;
                        popup_on_n = 1'b1;
                        pointer_n  = RISE_START;
                        fade_n     = 8'd0;
                    end else if (!fifo_empty_s) begin
                        text_n     = award_text(fifo_dout_s);
                        fifo_pop_s = 1'b1;
                        state_n    = ST_RISE;
                        popup_on_n = 1'b1;
                        pointer_n  = RISE_START;
                        fade_n     = 8'd0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_RISE: begin
                    // The frame showing pointer==0 still belongs to the rise.
                    if (pointer_r == 11'd0) begin
                        state_n    = ST_HOLD;
                        hold_cnt_n = {HOLD_W{1'b0}};
                    end else begin
                        pointer_n = pointer_r - 11'd1;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_n    = ST_FADE;
                        fade_cnt_n = FADE_W'(1'b1);
                        fade_n     = sat_fade(32'd1, FADE_STEP_U);
                    end else begin
                        hold_cnt_n = hold_cnt_r + HOLD_W'(1'b1);
                    end
                end
                ST_FADE: begin
                    if (fade_cnt_r == FADE_LAST) begin
                        state_n    = ST_IDLE;
                        popup_on_n = 1'b0;
                        fade_n     = 8'd0;
                        pointer_n  = 11'd0;
                        text_n     = TEXT_BLANK;
                    end else begin
                        fade_cnt_n = fade_cnt_r + FADE_W'(1'b1);
                        fade_n     = sat_fade(32'(fade_cnt_r) + 32'd1, FADE_STEP_U);
                    end
                end
                default: begin
                    state_n    = ST_IDLE;
                    pointer_n  = 11'd0;
                    fade_n     = 8'd0;
                    text_n     = TEXT_BLANK;
                    popup_on_n = 1'b0;
                end
            endcase

            // A new pulse re-arms the request even in the frame the old one loads.
            if (lvl_valid) begin
                lvl_pend_n = 1'b1;
                lvl_num_n  = lvl_num;
            end else begin
                lvl_num_n = lvl_num_r;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge frame_clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            pointer_r  <= 11'd0;
            hold_cnt_r <= {HOLD_W{1'b0}};
            fade_cnt_r <= {FADE_W{1'b0}};
            fade_r     <= 8'd0;
            text_r     <= TEXT_BLANK;
            popup_on_r <= 1'b0;
            lvl_pend_r <= 1'b0;
            lvl_num_r  <= 4'd0;
        end else begin
            state_r    <= state_n;
            pointer_r  <= pointer_n;
            hold_cnt_r <= hold_cnt_n;
            fade_cnt_r <= fade_cnt_n;
            fade_r     <= fade_n;
            text_r     <= text_n;
            popup_on_r <= popup_on_n;
            lvl_pend_r <= lvl_pend_n;
            lvl_num_r  <= lvl_num_n;
        end
    end

endmodule

// File: tb/tb_score_popup_sched.sv
// Self-checking bench for score_popup_sched: directed scenarios plus random
// traffic, compared each frame against a popup-timeline reference model.
module tb_score_popup_sched;

    localparam int DEPTH    = 4;
    localparam int RISE     = 16;
    localparam int HOLD     = 30;
    localparam int FADE_N   = 32;
    localparam int STEP     = 8;
    localparam int FADE_T0  = RISE + 1 + HOLD;          // first fade frame
    localparam int LAST_T   = FADE_T0 + FADE_N - 1;     // last visible frame

    logic        frame_clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        award_valid;
    logic [7:0]  award_points;
    logic        award_ready;
    logic        lvl_valid;
    logic [3:0]  lvl_num;
    logic        popup_on;
    logic [23:0] popup_text;
    logic [10:0] pointer;
    logic [7:0]  fade;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // reference model: a queue of points and a frame index into the popup
    int          m_q[$];
    bit          m_pend;
    int          m_num;
    bit          m_active;
    int          m_t;
    logic [23:0] m_text;

    logic [23:0] seen[$];
    bit          prev_on;

    score_popup_sched dut (
        .frame_clk    (frame_clk),
        .reset        (reset),
        .clear        (clear),
        .award_valid  (award_valid),
        .award_points (award_points),
        .award_ready  (award_ready),
        .lvl_valid    (lvl_valid),
        .lvl_num      (lvl_num),
        .popup_on     (popup_on),
        .popup_text   (popup_text),
        .pointer      (pointer),
        .fade         (fade),
        .busy         (busy)
    );

    always #5 frame_clk = ~frame_clk;

    function automatic logic [23:0] ref_award(input int pts);
        int p;
        int tens;
        int ones;
        logic [7:0] c1;
        p    = (pts > 99) ? 99 : pts;
        tens = p / 10;
        ones = p % 10;
        c1   = (tens == 0) ? 8'h20 : 8'(8'h30 + tens);
        return {8'h2B, c1, 8'(8'h30 + ones)};
    endfunction

    function automatic logic [23:0] ref_level(input int n);
        int d;
        d = (n > 9) ? 9 : n;
        return {8'h4C, 8'h56, 8'(8'h30 + d)};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pend   = 1'b0;
        m_num    = 0;
        m_active = 1'b0;
        m_t      = 0;
        m_text   = 24'h202020;
    endtask

    task automatic model_step(input bit clr, input bit av, input int pts, input bit lv, input int num);
        bit rdy;
        if (clr) begin
            model_reset();
        end else begin
            rdy = (m_q.size() < DEPTH);
            if (m_active) begin
                if (m_t == LAST_T) begin
                    m_active = 1'b0;
                    m_text   = 24'h202020;
                end else begin
                    m_t++;
                end
            end else if (m_pend) begin
                m_text   = ref_level(m_num);
                m_pend   = 1'b0;
                m_active = 1'b1;
                m_t      = 0;
            end else if (m_q.size() > 0) begin
                m_text   = ref_award(m_q.pop_front());
                m_active = 1'b1;
                m_t      = 0;
            end
            if (av && rdy) m_q.push_back(pts);
            if (lv) begin
                m_pend = 1'b1;
                m_num  = num;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int e_ptr;
        int e_fade;
        e_ptr  = (m_active && m_t <= RISE) ? (RISE - m_t) : 0;
        e_fade = 0;
        if (m_active && m_t >= FADE_T0) begin
            e_fade = (m_t - FADE_T0 + 1) * STEP;
            if (e_fade > 255) e_fade = 255;
        end
        chk("popup_on",    32'(popup_on),    32'(m_active));
        chk("popup_text",  32'(popup_text),  32'(m_text));
        chk("pointer",     32'(pointer),     32'(e_ptr));
        chk("fade",        32'(fade),        32'(e_fade));
        chk("award_ready", 32'(award_ready), 32'(m_q.size() < DEPTH));
        chk("busy",        32'(busy),        32'(m_active || m_pend || (m_q.size() > 0)));
        if (popup_on === 1'b1 && !prev_on) seen.push_back(popup_text);
        prev_on = (popup_on === 1'b1);
    endtask

    task automatic cyc(input bit clr, input bit av, input logic [7:0] pts, input bit lv, input logic [3:0] num);
        clear        = clr;
        award_valid  = av;
        award_points = pts;
        lvl_valid    = lv;
        lvl_num      = num;
        @(posedge frame_clk);
        model_step(clr, av, int'(pts), lv, int'(num));
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 8'd0, 1'b0, 4'd0);
    endtask

    // hold the request until the model says it was taken, bounded
    task automatic send_award(input logic [7:0] pts);
        bit acc;
        int guard;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 200) begin
            acc = (m_q.size() < DEPTH);
            cyc(1'b0, 1'b1, pts, 1'b0, 4'd0);
            guard++;
        end
        chk("award_accept_timeout", 32'(acc), 32'd1);
    endtask

    initial begin
        reset        = 1'b1;
        clear        = 1'b0;
        award_valid  = 1'b0;
        award_points = 8'd0;
        lvl_valid    = 1'b0;
        lvl_num      = 4'd0;
        prev_on      = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge frame_clk);
        #1;
        check_all();
        chk("reset_text", 32'(popup_text), 32'h202020);
        reset = 1'b0;

        // award 5: timeline landmarks relative to the load frame
        send_award(8'd5);
        chk("pre_load_on", 32'(popup_on), 32'd0);
        idle(1);
        chk("award5_text", 32'(popup_text), 32'h2B2035);
        chk("award5_ptr0", 32'(pointer), 32'd16);
        idle(16);
        chk("frame16_ptr", 32'(pointer), 32'd0);
        chk("frame16_on",  32'(popup_on), 32'd1);
        idle(31);
        chk("frame47_fade", 32'(fade), 32'd8);
        idle(31);
        chk("frame78_fade", 32'(fade), 32'hFF);
        idle(1);
        chk("frame79_on", 32'(popup_on), 32'd0);
        idle(3);

        // award 150 saturates to 99
        send_award(8'd150);
        idle(1);
        chk("award150_text", 32'(popup_text), 32'h2B3939);
        idle(85);

        // five back-to-back awards, drained in push order
        seen.delete();
        send_award(8'd11);
        send_award(8'd22);
        send_award(8'd33);
        send_award(8'd44);
        send_award(8'd55);
        idle(5 * 80 + 10);
        chk("b2b_count", 32'(seen.size()), 32'd5);
        if (seen.size() == 5) begin
            chk("b2b_0", 32'(seen[0]), 32'h2B3131);
            chk("b2b_1", 32'(seen[1]), 32'h2B3232);
            chk("b2b_2", 32'(seen[2]), 32'h2B3333);
            chk("b2b_3", 32'(seen[3]), 32'h2B3434);
            chk("b2b_4", 32'(seen[4]), 32'h2B3535);
        end

        // level-up overtakes a queued award
        seen.delete();
        send_award(8'd10);
        idle(3);
        send_award(8'd20);
        cyc(1'b0, 1'b0, 8'd0, 1'b1, 4'd3);
        idle(3 * 80 + 10);
        chk("lvl_prio_count", 32'(seen.size()), 32'd3);
        if (seen.size() == 3) begin
            chk("lvl_prio_0", 32'(seen[0]), 32'h2B3130);
            chk("lvl_prio_1", 32'(seen[1]), 32'h4C5633);
            chk("lvl_prio_2", 32'(seen[2]), 32'h2B3230);
        end

        // level 12 clamps to 9; a second pulse overwrites the first
        seen.delete();
        cyc(1'b0, 1'b0, 8'd0, 1'b1, 4'd12);
        idle(5);
        cyc(1'b0, 1'b0, 8'd0, 1'b1, 4'd2);
        idle(2);
        cyc(1'b0, 1'b0, 8'd0, 1'b1, 4'd4);
        idle(200);
        chk("lvl_ovr_count", 32'(seen.size()), 32'd2);
        if (seen.size() == 2) begin
            chk("lvl_clamp", 32'(seen[0]), 32'h4C5639);
            chk("lvl_ovr",   32'(seen[1]), 32'h4C5634);
        end

        // clear mid-HOLD with three awards queued
        send_award(8'd1);
        idle(1);
        send_award(8'd2);
        send_award(8'd3);
        send_award(8'd4);
        idle(27);
        chk("pre_clear_on", 32'(popup_on), 32'd1);
        cyc(1'b1, 1'b1, 8'd9, 1'b1, 4'd7);
        chk("clear_on",    32'(popup_on), 32'd0);
        chk("clear_busy",  32'(busy), 32'd0);
        chk("clear_ready", 32'(award_ready), 32'd1);
        seen.delete();
        idle(200);
        chk("post_clear_popups", 32'(seen.size()), 32'd0);

        // random traffic against the model
        for (int i = 0; i < 2500; i++) begin
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 5) == 0),
                8'($urandom_range(0, 255)),
                ($urandom_range(0, 59) == 0),
                4'($urandom_range(0, 15)));
        end
        idle(10);

        // asynchronous reset in the middle of a popup
        send_award(8'd77);
        idle(20);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("async_rst_on", 32'(popup_on), 32'd0);
        @(negedge frame_clk);
        reset = 1'b0;
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
